pixel_streamer: RTL and testbench

Source side of the convolution pixel interface. Holds one N×N 8-bit image in a local frame buffer, loaded through a simple write port. On command, it replays the image in raster order (row 0 col 0 first) as a `pixel` / `data_in_en` beat stream, exactly the form the convolution front end consumes. It sits between the host/testbench loader and the convolution pipeline, and provides a hold input and a completion pulse.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/pixel_frame_ram.sv | 35 +++
 rtl/pixel_streamer.sv | 147 ++++++++++++++
 tb/tb_pixel_streamer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ============================================================================
// conv_pkg -- shared constants, pixel type and streamer FSM encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int CONV_N     = 10;
    localparam int CONV_PIX_W = 8;

    typedef logic [CONV_PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } streamer_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_frame_ram.sv
// ============================================================================
// pixel_frame_ram -- N*N pixel frame store, one synchronous write port and
// one combinational read port. Contents are not reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_frame_ram
    import conv_pkg::*;
#(
    parameter int N      = CONV_N,
    parameter int PIX_W  = CONV_PIX_W,
    parameter int ADDR_W = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] r_mem [0:N*N-1];

    always_ff @(posedge clk) begin : p_write
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/pixel_streamer.sv
// ============================================================================
// pixel_streamer -- replays a stored N*N frame in raster order as a
// pixel/data_in_en beat stream. Optional PIXEL_STREAMER_ROW_GAP_EN inserts
// one idle cycle after every row.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_streamer
    import conv_pkg::*;
#(
    parameter int N     = CONV_N,
    parameter int PIX_W = CONV_PIX_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [$clog2(N*N)-1:0] wr_addr,
    input  logic [PIX_W-1:0]       wr_data,
    input  logic                   start,
    input  logic                   hold,
    output logic [PIX_W-1:0]       pixel,
    output logic                   data_in_en,
    output logic                   busy,
    output logic                   done
);

    localparam int c_addr_w = $clog2(N*N);
    localparam int c_cnt_w  = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N-1);

    streamer_state_t     r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_i, r_j, w_i_nxt, w_j_nxt;
    logic [PIX_W-1:0]    r_pixel, w_pixel_nxt;
    logic                r_den, w_den_nxt;
    logic                r_done, w_done_nxt;
    logic                w_mem_we;
    logic [c_addr_w-1:0] w_rd_addr;
    logic [PIX_W-1:0]    w_rd_data;

    assign w_rd_addr = c_addr_w'(r_i) * c_addr_w'(N) + c_addr_w'(r_j);

    pixel_frame_ram #(
        .N      (N),
        .PIX_W  (PIX_W),
        .ADDR_W (c_addr_w)
    ) u_ram (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (w_rd_addr),
        .rdata (w_rd_data)
    );

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_pixel_nxt = r_pixel;
        w_den_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_mem_we    = 1'b0;
        case (r_state)
            IDLE: begin
                // start wins over a same-cycle write
                if (start) begin
                    w_state_nxt = STREAM;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                end else if (wr_en && (32'(wr_addr) < 32'(N*N))) begin
                    w_mem_we = 1'b1;
                end
            end
            STREAM: begin
                if (!hold) begin
                    w_pixel_nxt = w_rd_data;
                    w_den_nxt   = 1'b1;
                    if (r_j == c_last) begin
                        w_j_nxt = '0;
`ifdef PIXEL_STREAMER_ROW_GAP_EN
                        // row index advances on leaving GAP
                        w_state_nxt = GAP;
`else
                        if (r_i == c_last) begin
                            w_i_nxt     = '0;
                            w_state_nxt = DONE;
                        end else begin
                            w_i_nxt = r_i + 1'b1;
                        end
`endif
                    end else begin
                        w_j_nxt = r_j + 1'b1;
                    end
                end
            end
`ifdef PIXEL_STREAMER_ROW_GAP_EN
            GAP: begin
                if (r_i == c_last) begin
                    w_i_nxt     = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_i_nxt     = r_i + 1'b1;
                    w_state_nxt = STREAM;
                end
            end
`endif
            DONE: begin
                // stay one extra cycle so busy covers the done pulse
                if (!r_done) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin : p_regs
        if (reset) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_pixel <= '0;
            r_den   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_pixel <= w_pixel_nxt;
            r_den   <= w_den_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign pixel      = r_pixel;
    assign data_in_en = r_den;
    assign done       = r_done;
    assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pixel_streamer.sv
// ============================================================================
// tb_pixel_streamer -- directed self-checking bench for pixel_streamer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pixel_streamer;
    import conv_pkg::*;

    localparam int NN = CONV_N * CONV_N;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [6:0] wr_addr;
    pixel_t     wr_data;
    logic       start;
    logic       hold;
    pixel_t     pixel;
    logic       data_in_en;
    logic       busy;
    logic       done;

    int     n_checks = 0;
    int     n_errors = 0;
    pixel_t exp_mem [NN];

    pixel_streamer #(.N(CONV_N), .PIX_W(CONV_PIX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .hold       (hold),
        .pixel      (pixel),
        .data_in_en (data_in_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int addr, input pixel_t data);
        wr_en   = 1'b1;
        wr_addr = 7'(addr);
        wr_data = data;
        step();
        wr_en = 1'b0;
        if (addr < NN) exp_mem[addr] = data;
    endtask

    task automatic run_stream(input int hold_after, input int hold_len, input int poke_after,
                              input int rst_after, input bit wr_with_start);
        int  b = 0;
        int  e = 0;
        int  hold_left = 0;
        bit  gap = 0;
        bit  hold_now, gap_now;
        bit  hold_armed = 0;
        bit  poked = 0;
        bit  aborted = 0;
        bit  got_done = 0;
        int  exp_lat;
        if (wr_with_start) begin
            wr_en   = 1'b1;
            wr_addr = 7'd0;
            wr_data = 8'hAA;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_after_start", busy, 1);
        while (b < NN && e < 3 * NN) begin
            hold_now = hold;
            gap_now  = gap;
            step();
            e++;
            check("busy_run", busy, 1);
            check("done_early", done, 0);
            if (gap_now) begin
                check("gap_den", data_in_en, 0);
                gap = 0;
            end else if (hold_now) begin
                check("hold_den", data_in_en, 0);
                check("hold_pix", pixel, exp_mem[b-1]);
                hold_left--;
            end else begin
                check("beat_den", data_in_en, 1);
                check("beat_pix", pixel, exp_mem[b]);
                b++;
`ifdef PIXEL_STREAMER_ROW_GAP_EN
                if (b % CONV_N == 0) gap = 1;
`endif
            end
            if (b == hold_after + 1 && !hold_armed) begin
                hold_left  = hold_len;
                hold_armed = 1;
            end
            hold = (hold_left > 0);
            if (b == poke_after + 1 && !poked) begin
                wr_en   = 1'b1;
                wr_addr = 7'd5;
                wr_data = 8'hFF;
                start   = 1'b1;
                poked   = 1;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (b == rst_after + 1) begin
                reset = 1'b1;
                #1;
                check("rst_pix", pixel, 0);
                check("rst_den", data_in_en, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                #1;
                reset   = 1'b0;
                aborted = 1;
                break;
            end
        end
        hold = 1'b0;
        if (!aborted) begin
            check("beat_count", b, NN);
`ifdef PIXEL_STREAMER_ROW_GAP_EN
            exp_lat = NN + CONV_N + 1 + hold_len;
`else
            exp_lat = NN + 1 + hold_len;
`endif
            for (int w = 0; w < CONV_N + 4 && !got_done; w++) begin
                step();
                e++;
                if (done) got_done = 1;
                else check("post_den", data_in_en, 0);
            end
            check("done_seen", got_done, 1);
            check("done_lat", e, exp_lat);
            check("done_busy", busy, 1);
            check("done_den", data_in_en, 0);
            step();
            check("done_pulse", done, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        hold    = 1'b0;
        #1;
        check("reset_pix", pixel, 0);
        check("reset_den", data_in_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        step();
        step();
        reset = 1'b0;
        step();

        for (int a = 0; a < NN; a++) write_px(a, pixel_t'(a));

        run_stream(-1, 0, -1, -1, 0);   // plain replay
        run_stream(23, 3, -1, -1, 0);   // hold after pixel 23
        run_stream(-1, 0, 10, -1, 0);   // write + start while busy
        run_stream(-1, 0, -1, -1, 0);   // pixel 5 must still be 5
        run_stream(-1, 0, -1, 40, 0);   // reset after pixel 40
        run_stream(-1, 0, -1, -1, 0);   // memory retained
        run_stream(-1, 0, -1, -1, 1);   // write dropped on start
        write_px(100, 8'h77);           // out-of-range address
        write_px(7, 8'h5A);
        run_stream(-1, 0, -1, -1, 0);   // new data streamed next cycle

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
